// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 serial byte receiver with mid-bit sampling,
// start-bit glitch rejection and stop-bit framing check.
module uart_byte_rx #(
  parameter int BAUD         = 9600,
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int BAUD_CNT_MAX = CLOCK_FREQ / BAUD - 1,
  parameter int BAUD_CNT_MID = BAUD_CNT_MAX / 2
) (
  input  logic       i_sysclk,
  input  logic       i_rst,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_rx_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam logic [29:0] CNT_MAX = 30'(BAUD_CNT_MAX);
  localparam logic [29:0] CNT_MID = 30'(BAUD_CNT_MID);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        r_rx_s1;
  logic        r_rx_s2;
  logic        r_rx_d;
  logic [1:0]  r_vld;
  logic        r_armed;
  logic [29:0] r_cnt;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        fall;
  logic        sample;

  // r_armed only rises once a real high has reached r_rx_s2, so a line
  // that is already low when reset is released never looks like a start.
  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_d  <= 1'b1;
      r_vld   <= 2'b00;
      r_armed <= 1'b0;
    end else begin
      r_rx_s1 <= i_uart_rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_d  <= r_rx_s2;
      r_vld   <= {r_vld[0], 1'b1};
      r_armed <= r_armed | (r_vld[1] & r_rx_s2);
    end
  end

  assign fall   = r_armed & r_rx_d & ~r_rx_s2;
  assign sample = (r_cnt == CNT_MID);

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (fall) state_nxt = START;
      end
      START: begin
        if (sample) state_nxt = r_rx_s2 ? IDLE : DATA;
      end
      DATA: begin
        if (sample && r_bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP: begin
        if (sample) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state != IDLE);
  end

  always_ff @(posedge i_sysclk) begin
    if (i_rst) begin
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      o_data      <= '0;
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      o_rx_done   <= 1'b0;
      o_frame_err <= 1'b0;
      if (state == IDLE || state_nxt == IDLE || r_cnt == CNT_MAX) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 30'd1;
      end
      unique case (state)
        START: begin
          if (sample) r_bit_idx <= '0;
        end
        DATA: begin
          if (sample) begin
            r_shift[r_bit_idx] <= r_rx_s2;
            r_bit_idx          <= r_bit_idx + 3'd1;
          end
        end
        STOP: begin
          if (sample) begin
            if (r_rx_s2) begin
              o_data    <= r_shift;
              o_rx_done <= 1'b1;
            end else begin
              o_frame_err <= 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
